// File: rtl/pc_gen.sv
// pc_gen: fetch PC generator with redirect epoch tagging and a 2-entry refetch-target FIFO.
module pc_gen #(
   parameter int              PC_W      = 16,
   parameter int              FETCH_INC = 4,
   parameter logic [PC_W-1:0] RESET_PC  = 16'h0000,
   parameter int              EPOCH_W   = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [2:0]         PC_select,
   input  logic [PC_W-1:0]    brch_tgt0,
   input  logic [PC_W-1:0]    brch_tgt1,
   input  logic [PC_W-1:0]    jump_tgt,
   input  logic [PC_W-1:0]    recovery_pc,
   input  logic               bh_push,
   input  logic [PC_W-1:0]    bh_pc,
   output logic [PC_W-1:0]    pc,
   output logic               pc_valid,
   output logic [EPOCH_W-1:0] epoch,
   output logic               bh_full,
   output logic               bh_empty,
   output logic               sel_err
);
   logic [PC_W-1:0]    pc_q, pc_d;
   logic               pc_valid_q, pc_valid_d;
   logic [EPOCH_W-1:0] epoch_q, epoch_d;
   logic               sel_err_q, sel_err_d;
   logic [PC_W-1:0]    fifo_q [2];
   logic [PC_W-1:0]    fifo_d [2];
   logic               head_q, head_d;
   logic [1:0]         cnt_q, cnt_d;
   logic               flush, pop, push_ok, push_drop;

   always_comb begin
      flush      = PC_select == 3'd3;
      pop        = PC_select == 3'd4 && cnt_q != 2'd0;
      push_ok    = bh_push && !flush && (cnt_q != 2'd2 || pop);
      push_drop  = bh_push && !flush && cnt_q == 2'd2 && !pop;
      pc_d       = pc_q;
      pc_valid_d = 1'b1;
      epoch_d    = epoch_q + EPOCH_W'(1);
      fifo_d     = fifo_q;
      case (PC_select)
         3'd0: pc_d = brch_tgt0;
         3'd1: pc_d = brch_tgt1;
         3'd2: pc_d = jump_tgt;
         3'd3: pc_d = recovery_pc;
         3'd4: begin
            pc_d       = pop ? fifo_q[head_q] : pc_q;
            pc_valid_d = pop;
            epoch_d    = pop ? epoch_q + EPOCH_W'(1) : epoch_q;
         end
         3'd5: begin
            pc_d    = pc_q + PC_W'(FETCH_INC);
            epoch_d = epoch_q;
         end
         3'd6: begin
            pc_valid_d = 1'b0;
            epoch_d    = epoch_q;
         end
         3'd7: begin
            pc_d       = RESET_PC;
            pc_valid_d = 1'b0;
            epoch_d    = '0;
         end
      endcase
      sel_err_d = sel_err_q | (PC_select == 3'd7) | (PC_select == 3'd4 && !pop) | push_drop;
      // tail slot is head+occupancy mod 2; when full it is the slot being popped
      if (push_ok) fifo_d[head_q ^ cnt_q[0]] = bh_pc;
      head_d = head_q ^ pop;
      cnt_d  = flush ? 2'd0 : cnt_q + {1'b0, push_ok} - {1'b0, pop};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_q       <= RESET_PC;
         pc_valid_q <= 1'b0;
         epoch_q    <= '0;
         sel_err_q  <= 1'b0;
         head_q     <= 1'b0;
         cnt_q      <= 2'd0;
      end else begin
         pc_q       <= pc_d;
         pc_valid_q <= pc_valid_d;
         epoch_q    <= epoch_d;
         sel_err_q  <= sel_err_d;
         head_q     <= head_d;
         cnt_q      <= cnt_d;
         fifo_q     <= fifo_d;
      end
   end

   assign pc       = pc_q;
   assign pc_valid = pc_valid_q;
   assign epoch    = epoch_q;
   assign sel_err  = sel_err_q;
   assign bh_full  = cnt_q == 2'd2;
   assign bh_empty = cnt_q == 2'd0;
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed scenarios plus randomized traffic checked against a queue-based reference model.
module tb_pc_gen;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [2:0]  PC_select = 3'd6;
   logic [15:0] brch_tgt0 = '0, brch_tgt1 = '0, jump_tgt = '0, recovery_pc = '0, bh_pc = '0;
   logic        bh_push = 1'b0;
   logic [15:0] pc;
   logic        pc_valid, bh_full, bh_empty, sel_err;
   logic [2:0]  epoch;
   int          checks = 0, failures = 0;
   logic [15:0] m_pc = '0;
   logic        m_valid = 1'b0, m_err = 1'b0;
   int          m_epoch = 0;
   logic [15:0] m_q [$];

   pc_gen dut (
      .clk(clk), .rst_n(rst_n), .PC_select(PC_select),
      .brch_tgt0(brch_tgt0), .brch_tgt1(brch_tgt1), .jump_tgt(jump_tgt), .recovery_pc(recovery_pc),
      .bh_push(bh_push), .bh_pc(bh_pc),
      .pc(pc), .pc_valid(pc_valid), .epoch(epoch),
      .bh_full(bh_full), .bh_empty(bh_empty), .sel_err(sel_err)
   );

   always #5 clk = ~clk;

   task automatic model_step();
      if (!rst_n) begin
         m_pc = 16'h0000; m_valid = 1'b0; m_epoch = 0; m_err = 1'b0; m_q.delete();
         return;
      end
      if (PC_select <= 3'd3) begin
         m_pc = PC_select == 3'd0 ? brch_tgt0 : PC_select == 3'd1 ? brch_tgt1 :
                PC_select == 3'd2 ? jump_tgt : recovery_pc;
         m_valid = 1'b1; m_epoch = (m_epoch + 1) % 8;
      end else if (PC_select == 3'd4) begin
         if (m_q.size() > 0) begin
            m_pc = m_q.pop_front(); m_valid = 1'b1; m_epoch = (m_epoch + 1) % 8;
         end else begin
            m_valid = 1'b0; m_err = 1'b1;
         end
      end else if (PC_select == 3'd5) begin
         m_pc = 16'((32'(m_pc) + 4) % 65536); m_valid = 1'b1;
      end else if (PC_select == 3'd6) begin
         m_valid = 1'b0;
      end else begin
         m_pc = 16'h0000; m_valid = 1'b0; m_epoch = 0; m_err = 1'b1;
      end
      if (PC_select == 3'd3) m_q.delete();
      else if (bh_push) begin
         if (m_q.size() < 2) m_q.push_back(bh_pc);
         else m_err = 1'b1;
      end
   endtask

   task automatic drive(input logic r, input logic [2:0] s, input logic p, input logic [15:0] ppc, input logic [15:0] tgt);
      rst_n = r; PC_select = s; bh_push = p; bh_pc = ppc;
      brch_tgt0 = 16'($urandom); brch_tgt1 = 16'($urandom);
      jump_tgt = 16'($urandom); recovery_pc = 16'($urandom);
      case (s)
         3'd0: brch_tgt0 = tgt;
         3'd1: brch_tgt1 = tgt;
         3'd2: jump_tgt = tgt;
         3'd3: recovery_pc = tgt;
         default: ;
      endcase
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic test_reset();
      drive(1'b0, 3'd4, 1'b1, 16'h1234, 16'h0);
      drive(1'b0, 3'd7, 1'b1, 16'h5678, 16'h0);
      checks += 6;
      if (pc !== 16'h0000) begin failures++; $display("FAIL reset_pc got=%h exp=0000", pc); end
      if (pc_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", pc_valid); end
      if (epoch !== 3'd0) begin failures++; $display("FAIL reset_epoch got=%0d exp=0", epoch); end
      if (bh_empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", bh_empty); end
      if (bh_full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", bh_full); end
      if (sel_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", sel_err); end
   endtask

   task automatic test_sequential();
      for (int i = 1; i <= 3; i++) begin
         drive(1'b1, 3'd5, 1'b0, 16'h0, 16'h0);
         checks += 3;
         if (pc !== 16'(4 * i)) begin failures++; $display("FAIL seq_pc step=%0d got=%h exp=%h", i, pc, 16'(4 * i)); end
         if (pc_valid !== 1'b1) begin failures++; $display("FAIL seq_valid step=%0d got=%b exp=1", i, pc_valid); end
         if (epoch !== 3'd0) begin failures++; $display("FAIL seq_epoch step=%0d got=%0d exp=0", i, epoch); end
      end
   endtask

   task automatic test_jump_hold();
      drive(1'b1, 3'd2, 1'b0, 16'h0, 16'h0100);
      checks += 3;
      if (pc !== 16'h0100) begin failures++; $display("FAIL jump_pc got=%h exp=0100", pc); end
      if (pc_valid !== 1'b1) begin failures++; $display("FAIL jump_valid got=%b exp=1", pc_valid); end
      if (epoch !== 3'd1) begin failures++; $display("FAIL jump_epoch got=%0d exp=1", epoch); end
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 3'd6, 1'b0, 16'h0, 16'h0);
         checks += 3;
         if (pc !== 16'h0100) begin failures++; $display("FAIL hold_pc got=%h exp=0100", pc); end
         if (pc_valid !== 1'b0) begin failures++; $display("FAIL hold_valid got=%b exp=0", pc_valid); end
         if (epoch !== 3'd1) begin failures++; $display("FAIL hold_epoch got=%0d exp=1", epoch); end
      end
      drive(1'b1, 3'd5, 1'b0, 16'h0, 16'h0);
      checks += 2;
      if (pc !== 16'h0104) begin failures++; $display("FAIL after_hold_pc got=%h exp=0104", pc); end
      if (pc_valid !== 1'b1) begin failures++; $display("FAIL after_hold_valid got=%b exp=1", pc_valid); end
   endtask

   task automatic test_fifo();
      drive(1'b1, 3'd6, 1'b1, 16'h0200, 16'h0);
      checks += 2;
      if (bh_empty !== 1'b0) begin failures++; $display("FAIL fifo_empty1 got=%b exp=0", bh_empty); end
      if (bh_full !== 1'b0) begin failures++; $display("FAIL fifo_full1 got=%b exp=0", bh_full); end
      drive(1'b1, 3'd6, 1'b1, 16'h0300, 16'h0);
      checks += 2;
      if (bh_full !== 1'b1) begin failures++; $display("FAIL fifo_full2 got=%b exp=1", bh_full); end
      if (sel_err !== 1'b0) begin failures++; $display("FAIL fifo_err2 got=%b exp=0", sel_err); end
      drive(1'b1, 3'd6, 1'b1, 16'h0999, 16'h0);
      checks += 2;
      if (sel_err !== 1'b1) begin failures++; $display("FAIL overflow_err got=%b exp=1", sel_err); end
      if (bh_full !== 1'b1) begin failures++; $display("FAIL overflow_full got=%b exp=1", bh_full); end
      drive(1'b1, 3'd4, 1'b0, 16'h0, 16'h0);
      checks += 3;
      if (pc !== 16'h0200) begin failures++; $display("FAIL pop1_pc got=%h exp=0200", pc); end
      if (pc_valid !== 1'b1) begin failures++; $display("FAIL pop1_valid got=%b exp=1", pc_valid); end
      if (epoch !== 3'd2) begin failures++; $display("FAIL pop1_epoch got=%0d exp=2", epoch); end
      drive(1'b1, 3'd4, 1'b0, 16'h0, 16'h0);
      checks += 3;
      if (pc !== 16'h0300) begin failures++; $display("FAIL pop2_pc got=%h exp=0300", pc); end
      if (bh_empty !== 1'b1) begin failures++; $display("FAIL pop2_empty got=%b exp=1", bh_empty); end
      if (epoch !== 3'd3) begin failures++; $display("FAIL pop2_epoch got=%0d exp=3", epoch); end
   endtask

   task automatic test_flush();
      drive(1'b1, 3'd6, 1'b1, 16'h0777, 16'h0);
      drive(1'b0, 3'd4, 1'b1, 16'h0888, 16'h0);
      checks += 4;
      if (pc !== 16'h0000) begin failures++; $display("FAIL midreset_pc got=%h exp=0000", pc); end
      if (pc_valid !== 1'b0) begin failures++; $display("FAIL midreset_valid got=%b exp=0", pc_valid); end
      if (bh_empty !== 1'b1) begin failures++; $display("FAIL midreset_empty got=%b exp=1", bh_empty); end
      if (sel_err !== 1'b0) begin failures++; $display("FAIL midreset_err got=%b exp=0", sel_err); end
      drive(1'b1, 3'd6, 1'b1, 16'h0400, 16'h0);
      drive(1'b1, 3'd3, 1'b1, 16'h0500, 16'h0050);
      checks += 4;
      if (pc !== 16'h0050) begin failures++; $display("FAIL flush_pc got=%h exp=0050", pc); end
      if (bh_empty !== 1'b1) begin failures++; $display("FAIL flush_empty got=%b exp=1", bh_empty); end
      if (sel_err !== 1'b0) begin failures++; $display("FAIL flush_err got=%b exp=0", sel_err); end
      if (epoch !== 3'd1) begin failures++; $display("FAIL flush_epoch got=%0d exp=1", epoch); end
   endtask

   task automatic test_empty_pop();
      drive(1'b1, 3'd2, 1'b0, 16'h0, 16'h0010);
      drive(1'b1, 3'd4, 1'b0, 16'h0, 16'h0);
      checks += 4;
      if (pc !== 16'h0010) begin failures++; $display("FAIL emptypop_pc got=%h exp=0010", pc); end
      if (pc_valid !== 1'b0) begin failures++; $display("FAIL emptypop_valid got=%b exp=0", pc_valid); end
      if (sel_err !== 1'b1) begin failures++; $display("FAIL emptypop_err got=%b exp=1", sel_err); end
      if (epoch !== 3'd2) begin failures++; $display("FAIL emptypop_epoch got=%0d exp=2", epoch); end
   endtask

   task automatic test_illegal();
      drive(1'b1, 3'd7, 1'b0, 16'h0, 16'h0);
      checks += 4;
      if (pc !== 16'h0000) begin failures++; $display("FAIL illegal_pc got=%h exp=0000", pc); end
      if (pc_valid !== 1'b0) begin failures++; $display("FAIL illegal_valid got=%b exp=0", pc_valid); end
      if (epoch !== 3'd0) begin failures++; $display("FAIL illegal_epoch got=%0d exp=0", epoch); end
      if (sel_err !== 1'b1) begin failures++; $display("FAIL illegal_err got=%b exp=1", sel_err); end
      drive(1'b1, 3'd5, 1'b0, 16'h0, 16'h0);
      checks += 1;
      if (pc !== 16'h0004) begin failures++; $display("FAIL illegal_next_pc got=%h exp=0004", pc); end
   endtask

   task automatic test_epoch_wrap();
      logic [15:0] t;
      drive(1'b0, 3'd6, 1'b0, 16'h0, 16'h0);
      for (int i = 0; i < 9; i++) begin
         t = 16'($urandom);
         drive(1'b1, 3'd1, 1'b0, 16'h0, t);
         checks += 2;
         if (epoch !== 3'((i + 1) % 8)) begin failures++; $display("FAIL wrap_epoch step=%0d got=%0d exp=%0d", i, epoch, (i + 1) % 8); end
         if (pc !== t) begin failures++; $display("FAIL wrap_pc step=%0d got=%h exp=%h", i, pc, t); end
      end
      drive(1'b1, 3'd2, 1'b0, 16'h0, 16'hFFFC);
      drive(1'b1, 3'd5, 1'b0, 16'h0, 16'h0);
      checks += 2;
      if (pc !== 16'h0000) begin failures++; $display("FAIL pc_wrap got=%h exp=0000", pc); end
      if (pc_valid !== 1'b1) begin failures++; $display("FAIL pc_wrap_valid got=%b exp=1", pc_valid); end
   endtask

   task automatic test_back_to_back();
      drive(1'b0, 3'd6, 1'b0, 16'h0, 16'h0);
      drive(1'b1, 3'd6, 1'b1, 16'h0A00, 16'h0);
      drive(1'b1, 3'd6, 1'b1, 16'h0B00, 16'h0);
      drive(1'b1, 3'd4, 1'b1, 16'h0C00, 16'h0);
      checks += 3;
      if (pc !== 16'h0A00) begin failures++; $display("FAIL b2b_pop1 got=%h exp=0A00", pc); end
      if (bh_full !== 1'b1) begin failures++; $display("FAIL b2b_full got=%b exp=1", bh_full); end
      if (sel_err !== 1'b0) begin failures++; $display("FAIL b2b_err got=%b exp=0", sel_err); end
      drive(1'b1, 3'd4, 1'b0, 16'h0, 16'h0);
      checks += 1;
      if (pc !== 16'h0B00) begin failures++; $display("FAIL b2b_pop2 got=%h exp=0B00", pc); end
      drive(1'b1, 3'd4, 1'b0, 16'h0, 16'h0);
      checks += 2;
      if (pc !== 16'h0C00) begin failures++; $display("FAIL b2b_pop3 got=%h exp=0C00", pc); end
      if (bh_empty !== 1'b1) begin failures++; $display("FAIL b2b_empty got=%b exp=1", bh_empty); end
      drive(1'b1, 3'd4, 1'b1, 16'h0D00, 16'h0);
      checks += 3;
      if (pc_valid !== 1'b0) begin failures++; $display("FAIL emptypush_valid got=%b exp=0", pc_valid); end
      if (bh_empty !== 1'b0) begin failures++; $display("FAIL emptypush_empty got=%b exp=0", bh_empty); end
      if (sel_err !== 1'b1) begin failures++; $display("FAIL emptypush_err got=%b exp=1", sel_err); end
      drive(1'b1, 3'd4, 1'b0, 16'h0, 16'h0);
      checks += 1;
      if (pc !== 16'h0D00) begin failures++; $display("FAIL emptypush_pop got=%h exp=0D00", pc); end
   endtask

   task automatic test_random();
      int r;
      logic [2:0] s;
      for (int i = 0; i < 500; i++) begin
         r = $urandom_range(0, 39);
         s = r < 38 ? 3'(r % 7) : 3'd7;
         drive($urandom_range(0, 49) != 0, s, $urandom_range(0, 2) == 0, 16'($urandom), 16'($urandom));
         checks += 6;
         if (pc !== m_pc) begin failures++; $display("FAIL rnd_pc cyc=%0d got=%h exp=%h", i, pc, m_pc); end
         if (pc_valid !== m_valid) begin failures++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", i, pc_valid, m_valid); end
         if (epoch !== 3'(m_epoch)) begin failures++; $display("FAIL rnd_epoch cyc=%0d got=%0d exp=%0d", i, epoch, m_epoch); end
         if (sel_err !== m_err) begin failures++; $display("FAIL rnd_err cyc=%0d got=%b exp=%b", i, sel_err, m_err); end
         if (bh_full !== (m_q.size() == 2)) begin failures++; $display("FAIL rnd_full cyc=%0d got=%b exp=%0d", i, bh_full, m_q.size() == 2); end
         if (bh_empty !== (m_q.size() == 0)) begin failures++; $display("FAIL rnd_empty cyc=%0d got=%b exp=%0d", i, bh_empty, m_q.size() == 0); end
      end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_jump_hold();
      test_fifo();
      test_flush();
      test_empty_pop();
      test_illegal();
      test_epoch_wrap();
      test_back_to_back();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/pc_gen.md
# pc_gen

Fetch-stage program-counter generator; the consumer of the 3-bit `PC_select` code produced by the next-PC selector. Each cycle it applies the selected source to the architectural fetch PC and tags fetch packets with a redirect epoch. It also buffers branch-handler refetch targets in a 2-entry FIFO so that code 4 always has a defined target. Its outputs drive the instruction-cache address and the fetch packet tag.

## Interface

Parameters:

- `PC_W`, 16, PC width in bits
- `FETCH_INC`, 4, sequential increment applied on code 5
- `RESET_PC`, 16'h0000, PC loaded on reset
- `EPOCH_W`, 3, redirect epoch counter width

Ports:

- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  reset, synchronous, active-low
- `PC_select`  in  3  source code: 0 brch_tgt0, 1 brch_tgt1, 2 jump_tgt, 3 recovery_pc, 4 FIFO head, 5 pc+FETCH_INC, 6 hold, 7 reset
- `brch_tgt0`  in  PC_W  predicted-taken target, first branch slot
- `brch_tgt1`  in  PC_W  predicted-taken target, second branch slot
- `jump_tgt`  in  PC_W  decoded jump target
- `recovery_pc`  in  PC_W  mispredict recovery PC
- `bh_push`  in  1  branch handler pushes a refetch target
- `bh_pc`  in  PC_W  refetch target written on push
- `pc`  out  PC_W  current fetch PC (registered)
- `pc_valid`  out  1  `pc` is a new fetch address this cycle
- `epoch`  out  EPOCH_W  redirect epoch of the current `pc`
- `bh_full`  out  1  FIFO holds 2 entries
- `bh_empty`  out  1  FIFO holds 0 entries
- `sel_err`  out  1  sticky protocol error flag

## Operation

- Reset (`rst_n`=0 at a clock edge) sets the following:
  - `pc`=`RESET_PC`, `pc_valid`=0, `epoch`=0.
  - FIFO cleared: `bh_empty`=1, `bh_full`=0.
  - `sel_err`=0.
  - All inputs are ignored while reset is applied.
- Next-PC selection:
  - Codes 0, 1, 2, 3 and 4 are redirects. Each loads its source into `pc`, sets `pc_valid`=1 and increments `epoch` modulo 2^EPOCH_W, wrapping 7 to 0.
  - Code 5 loads `pc`+`FETCH_INC`, truncated to PC_W (wraps at the top of the address space). It sets `pc_valid`=1 and leaves `epoch` unchanged.
  - Code 6 holds `pc` and `epoch` and sets `pc_valid`=0.
  - Code 7 with `rst_n`=1 is illegal. It loads `RESET_PC`, sets `pc_valid`=0, sets `epoch`=0 and sets `sel_err`.
- Refetch FIFO:
  - 2 entries, in-order.
  - `bh_push` writes `bh_pc` at the tail.
  - Code 4 pops the head, which is the value loaded into `pc`.
  - Push and pop in the same cycle are allowed at any occupancy except empty. Occupancy is unchanged and the head advances.
  - Push when full with no pop: the push is dropped and `sel_err` is set.
  - Code 4 when empty: `pc` holds, `pc_valid`=0, `epoch` is unchanged and `sel_err` is set. A same-cycle push is still accepted.
  - Code 3 (mispredict) flushes the FIFO to empty. A same-cycle `bh_push` is discarded as stale and does not set `sel_err`.
- `sel_err` is sticky until reset.

## Timing

- All outputs are registered. A code sampled at edge N is visible on `pc`/`pc_valid`/`epoch` after edge N.
- Latency is 1 cycle from select to PC. There are no redirect bubbles beyond what code 6 requests.
- `bh_full` and `bh_empty` reflect post-edge occupancy. A push at edge N is poppable by code 4 sampled at edge N+1.
- The source operands (`brch_tgt*`, `jump_tgt`, `recovery_pc`) are sampled at the same edge as `PC_select`.
- Priority within one cycle:
  1. reset
  2. code 3 flush
  3. FIFO push/pop
  4. `sel_err` update
- Reset mid-operation discards FIFO contents and the epoch. The first cycle after deassertion presents `RESET_PC` with `pc_valid`=0.

## Test plan

- Reset, then deassert and drive code 5 for three cycles with `RESET_PC`=0 and `FETCH_INC`=4. Required: `pc`=0,4,8,12; `epoch`=0; `pc_valid`=1 after the first code 5.
- Drive code 2 with `jump_tgt`=16'h0100, then code 6 twice, then code 5. Required: `pc`=0100 with `epoch`+1; then `pc_valid`=0 with `pc` held at 0100; then `pc`=0104.
- Push 0x0200 and 0x0300, drive a third push with no pop, then code 4 twice. Required:
  - `bh_full`=1 after the second push.
  - The third push sets `sel_err`=1.
  - The two pops give `pc`=0200 then 0300, and `bh_empty`=1 afterwards.
- Push 0x0400, then drive code 3 with `recovery_pc`=0x0050 and a simultaneous push of 0x0500. Required: `pc`=0050, `bh_empty`=1, `sel_err` still 0.
- Drive code 4 with the FIFO empty and `pc`=0x0010. Required: `pc` holds 0010, `pc_valid`=0, `sel_err`=1.
- Drive 9 consecutive code-1 redirects with `EPOCH_W`=3. Required: `epoch` runs 1…7, 0, 1. Also set `pc`=16'hFFFC and drive code 5. Required: `pc`=0000.
